window_scan_ctrl: RTL and testbench

- Raster-scan controller that feeds the 3x3 window generator.
- Accepts one pixel per cycle over a valid/ready handshake and stores the two previous image rows in internal line buffers.
- Drives the generator's three row inputs and its in_valid strobe.
- Emits win_valid and the window-centre coordinates, aligned to the generator's window registers, for fully interior windows only.
- Sits between the pixel source (frame reader) and the window generator / convolution datapath.

---
 rtl/window_pkg.sv | 16 +
 rtl/window_line_buffer.sv | 24 ++
 rtl/window_scan_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// Shared definitions for the window scan controller: controller FSM states,
// default pixel width and the fixed drain / window-latency cycle counts.
package window_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int DRAIN_CYCLES = 2;
  localparam int WIN_LATENCY  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/window_line_buffer.sv
// One image-row line buffer: IMG_W entries, combinational read and registered
// write at a shared address, so a read-modify-write in one cycle returns the
// previous contents. Contents are deliberately not reset.
module window_line_buffer #(
  parameter int IMG_W  = 32,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic [$clog2(IMG_W)-1:0] addr,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [IMG_W];

  assign rd_data = mem[addr];

  // Registered write; the row value read this cycle is the old one.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster-scan controller feeding a 3x3 window generator. Accepts one pixel
// per cycle, keeps the two previous rows in line buffers, drives the
// generator row inputs and in_valid strobe, and flags interior windows with
// their centre coordinates aligned to the generator's window registers.
// Optional feature macro: WSC_STALL_CNT_EN adds a saturating 16-bit count of
// RUN cycles without a valid pixel (output stall_cnt).
module window_scan_ctrl
  import window_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [DATA_W-1:0]        pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic [DATA_W-1:0]        r0,
  output logic [DATA_W-1:0]        r1,
  output logic [DATA_W-1:0]        r2,
  output logic                     col_valid,
  output logic                     win_valid,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y,
  output logic                     busy,
  output logic                     frame_done
`ifdef WSC_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            accept;
  logic            row_end;
  logic            frame_end;

  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] r0_q, r1_q, r2_q;
  logic              col_valid_q;

  logic              vld_p1_q;
  logic [XW-1:0]     wx_p1_q;
  logic [YW-1:0]     wy_p1_q;
  logic              vld_p2_q;
  logic [XW-1:0]     wx_p2_q;
  logic [YW-1:0]     wy_p2_q;

  assign accept    = (state_q == RUN) && pix_valid;
  assign row_end   = (x_q == XW'(IMG_W - 1));
  assign frame_end = row_end && (y_q == YW'(IMG_H - 1));

  // lb0 holds row y-2, lb1 holds row y-1; an accept shifts the column down.
  window_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb0 (
    .clk     (clk),
    .addr    (x_q),
    .wr_en   (accept),
    .wr_data (lb1_rd),
    .rd_data (lb0_rd)
  );

  window_line_buffer #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb1 (
    .clk     (clk),
    .addr    (x_q),
    .wr_en   (accept),
    .wr_data (pix_in),
    .rd_data (lb1_rd)
  );

  // FSM and scan-position state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      drain_q <= drain_d;
    end
  end

  // Next-state, raster position advance and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    drain_d    = drain_q;
    pix_ready  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      RUN: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          if (frame_end) begin
            state_d = DRAIN;
            drain_d = '0;
            x_d     = '0;
            y_d     = '0;
          end else if (row_end) begin
            x_d = '0;
            y_d = y_q + 1'b1;
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DCW'(DRAIN_CYCLES - 1)) state_d = DONE;
        else                                   drain_d = drain_q + 1'b1;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Generator row feed: registered column and in_valid strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_q        <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      col_valid_q <= 1'b0;
    end else begin
      col_valid_q <= accept;
      if (accept) begin
        r0_q <= lb0_rd;
        r1_q <= lb1_rd;
        r2_q <= pix_in;
      end
    end
  end

  // Window-valid pipeline: stage 1 aligns with col_valid, stage 2 with the
  // generator window registers. Only fully interior centres are flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      wx_p1_q  <= '0;
      wy_p1_q  <= '0;
      vld_p2_q <= 1'b0;
      wx_p2_q  <= '0;
      wy_p2_q  <= '0;
    end else begin
      vld_p1_q <= accept && (x_q >= XW'(2)) && (y_q >= YW'(2));
      wx_p1_q  <= x_q - 1'b1;
      wy_p1_q  <= y_q - 1'b1;
      // stage boundary p1 -> p2
      vld_p2_q <= vld_p1_q;
      wx_p2_q  <= wx_p1_q;
      wy_p2_q  <= wy_p1_q;
    end
  end

  assign r0        = r0_q;
  assign r1        = r1_q;
  assign r2        = r2_q;
  assign col_valid = col_valid_q;
  assign win_valid = vld_p2_q;
  assign win_x     = wx_p2_q;
  assign win_y     = wy_p2_q;

`ifdef WSC_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count RUN cycles with no pixel offered; cleared by a fresh frame start.
  always_ff @(posedge clk) begin
    if (rst)                                stall_cnt_q <= '0;
    else if ((state_q == IDLE) && start)    stall_cnt_q <= '0;
    else if ((state_q == RUN) && !pix_valid) stall_cnt_q <= sat_inc16(stall_cnt_q);
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl on a 4x4 frame with pixel = 4y+x.
// Includes a 3x3 generator model fed from r0..r2/col_valid so window
// contents can be compared against hand-derived pixel values.
module tb_window_scan_ctrl;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [DW-1:0] r0, r1, r2;
  logic          col_valid;
  logic          win_valid;
  logic [1:0]    win_x;
  logic [1:0]    win_y;
  logic          busy;
  logic          frame_done;
`ifdef WSC_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  window_scan_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .r0         (r0),
    .r1         (r1),
    .r2         (r2),
    .col_valid  (col_valid),
    .win_valid  (win_valid),
    .win_x      (win_x),
    .win_y      (win_y),
    .busy       (busy),
    .frame_done (frame_done)
`ifdef WSC_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_row(input int b);
    return {8'(b), 8'(b + 1), 8'(b + 2)};
  endfunction

  // Generator model: three column registers shifted on in_valid.
  logic [23:0] gc0, gc1, gc2;
  always @(posedge clk) begin
    if (col_valid === 1'b1) begin
      gc0 <= gc1;
      gc1 <= gc2;
      gc2 <= {r0, r1, r2};
    end
  end

  // Reference monitor: expected win_valid/coords/window from accept history.
  bit mon_en = 1'b0;
  int mx = 0, my = 0;
  bit d1v = 0, d2v = 0;
  int d1x = 0, d1y = 0, d2x = 0, d2y = 0;
  int pulse_cnt = 0, colv_cnt = 0;
  bit acc;

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("win_valid", win_valid, d2v);
      if (d2v) begin
        check_eq("win_x", win_x, d2x);
        check_eq("win_y", win_y, d2y);
        check_eq("win_row0", {gc0[23:16], gc1[23:16], gc2[23:16]}, exp_row(4*(d2y-1) + d2x-1));
        check_eq("win_row1", {gc0[15:8],  gc1[15:8],  gc2[15:8]},  exp_row(4*d2y + d2x-1));
        check_eq("win_row2", {gc0[7:0],   gc1[7:0],   gc2[7:0]},   exp_row(4*(d2y+1) + d2x-1));
      end
    end
    if (win_valid === 1'b1) pulse_cnt++;
    if (col_valid === 1'b1) colv_cnt++;
    acc = (pix_valid === 1'b1) && (pix_ready === 1'b1) && (rst !== 1'b1);
    d2v = d1v; d2x = d1x; d2y = d1y;
    d1v = acc && (mx >= 2) && (my >= 2);
    d1x = mx - 1; d1y = my - 1;
    if (acc) begin
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    if (rst === 1'b1) begin
      d1v = 0; d2v = 0; mx = 0; my = 0;
    end
  end

  // Drive pixels 0..n_pix-1; bub_mode 0 none, 1 random 50%, 2 fixed 5 bubbles.
  task automatic send_frame(input bit do_start, input int bub_mode, input int start_at, input int n_pix);
    if (do_start) begin
      @(posedge clk); #1;
      start = 1'b1; pix_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n_pix; i++) begin
      bit bub;
      bub = (bub_mode == 1) ? bit'($urandom % 2) :
            (bub_mode == 2) ? (i == 2 || i == 5 || i == 9 || i == 12 || i == 14) : 1'b0;
      if (bub) begin
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_in    = DW'(i);
      start     = (i == start_at);
      if (i == 1) begin
        check_eq("busy_run", busy, 1'b1);
        check_eq("ready_run", pix_ready, 1'b1);
      end
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bub_mode);
    int n = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_latency", n, 2);
`ifdef WSC_STALL_CNT_EN
    if (bub_mode == 2) check_eq("stall_cnt_done", stall_cnt, 16'd5);
`endif
    @(posedge clk); #1;
    check_eq("busy_after_done", busy, 1'b0);
  endtask

  task automatic run_frame(input string tag, input int bub_mode, input int start_at);
    int p0, c0;
    p0 = pulse_cnt; c0 = colv_cnt;
    send_frame(1'b1, bub_mode, start_at, W*H);
    wait_done(bub_mode);
    check_eq({tag, "_pulses"}, pulse_cnt - p0, 4);
    check_eq({tag, "_colv"}, colv_cnt - c0, 16);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_valid = 1'b1; pix_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", pix_ready, 1'b0);
    check_eq("rst_colv", col_valid, 1'b0);
    check_eq("rst_winv", win_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    check_eq("rst_rows", {r0, r1, r2}, 24'h0);
    check_eq("rst_winxy", {win_x, win_y}, 4'h0);
`ifdef WSC_STALL_CNT_EN
    check_eq("rst_stall", stall_cnt, 16'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; pix_valid = 1'b0;
    mon_en = 1'b1;

    run_frame("nogap", 0, -1);
    run_frame("bubble", 1, -1);
    run_frame("start_ign", 0, 6);

    // Abort a frame after 7 accepted pixels, then run a fresh frame.
    send_frame(1'b1, 0, -1, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_colv", col_valid, 1'b0);
    run_frame("after_rst", 0, -1);

    run_frame("stall5", 2, -1);
`ifdef WSC_STALL_CNT_EN
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("stall_clr", stall_cnt, 16'd0);
    send_frame(1'b0, 0, -1, W*H);
    wait_done(0);
`endif

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
